// File: rtl/minitb_ahb_pkg.sv
// Shared types and constants for the miniTB AHB-lite responder.
package minitb_ahb_pkg;

  // AHB transfer type encoding as seen on htrans.
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  // Responder data-phase state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DATA = 2'b10
  } slave_state_t;

  // Largest wait-state count the 4-bit counter can hold.
  localparam int MAX_WAIT = 15;

endpackage

// File: rtl/minitb_ahb_slave_mem_if.sv
// AHB-lite bus bundle between the miniTB master and the memory responder.
interface minitb_ahb_slave_mem_if
  import minitb_ahb_pkg::*;
#(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
);
  htrans_t                htrans;
  logic [addrWidth-1:0]   haddr;
  logic                   hwrite;
  logic [dataWidth-1:0]   hwdata;
  logic                   hready;
  logic [dataWidth-1:0]   hrdata;

  modport master (output htrans, haddr, hwrite, hwdata, input hready, hrdata);
  modport slave  (input htrans, haddr, hwrite, hwdata, output hready, hrdata);
endinterface

// File: rtl/minitb_ahb_ram.sv
// Word-addressed synchronous RAM: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module minitb_ahb_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Commit write data into the array.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Load the read register; it holds until the next read.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/minitb_ahb_slave_mem.sv
// AHB-lite memory responder for the miniTB master.
// Optional wait states are compiled in with MINITB_AHB_SLAVE_WAIT_EN;
// without it every transfer is zero-wait and hready stays 1.
module minitb_ahb_slave_mem
  import minitb_ahb_pkg::*;
#(
  parameter int addrWidth  = 8,
  parameter int dataWidth  = 32,
  parameter int waitStates = 0
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  minitb_ahb_slave_mem_if.slave bus
);
  slave_state_t         state_q;
  logic                 hready_q;
  logic [addrWidth-1:0] addr_q;
  logic                 write_q;
  logic                 bypass_q;
  logic [dataWidth-1:0] fwd_q;
  logic [dataWidth-1:0] ram_rdata_s;

  logic                 accept_s;
  logic                 wr_commit_s;
  logic                 rd_enter_s;
  logic                 rd_write_s;
  logic                 re_s;
  logic                 bypass_s;
  logic [addrWidth-1:0] rd_addr_s;

`ifdef MINITB_AHB_SLAVE_WAIT_EN
  localparam logic [3:0] WAIT_INIT =
    4'((waitStates > MAX_WAIT) ? MAX_WAIT : waitStates);
  logic [3:0] cnt_q;
`endif

  // Decode accept, write commit and which transfer (if any) enters DATA now.
  always_comb begin
    accept_s    = hready_q && ((bus.htrans == HTRANS_NONSEQ) ||
                               (bus.htrans == HTRANS_SEQ));
    wr_commit_s = (state_q == ST_DATA) && write_q;
`ifdef MINITB_AHB_SLAVE_WAIT_EN
    if (accept_s) begin
      rd_enter_s = (WAIT_INIT == 4'd0);
      rd_addr_s  = bus.haddr;
      rd_write_s = bus.hwrite;
    end else begin
      rd_enter_s = (state_q == ST_WAIT) && (cnt_q == 4'd1);
      rd_addr_s  = addr_q;
      rd_write_s = write_q;
    end
`else
    rd_enter_s = accept_s;
    rd_addr_s  = bus.haddr;
    rd_write_s = bus.hwrite;
`endif
    re_s     = rd_enter_s && !rd_write_s;
    // A read landing on the address being written this edge sees the new data.
    bypass_s = re_s && wr_commit_s && (rd_addr_s == addr_q);
  end

  // Data-phase FSM, address/control capture and read forwarding registers.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      hready_q <= 1'b1;
      addr_q   <= '0;
      write_q  <= 1'b0;
      bypass_q <= 1'b0;
      fwd_q    <= '0;
`ifdef MINITB_AHB_SLAVE_WAIT_EN
      cnt_q    <= 4'd0;
`endif
    end else begin
      if (accept_s) begin
        addr_q  <= bus.haddr;
        write_q <= bus.hwrite;
      end
      if (re_s) begin
        bypass_q <= bypass_s;
        fwd_q    <= bus.hwdata;
      end
      case (state_q)
        ST_IDLE, ST_DATA: begin
          if (accept_s) begin
`ifdef MINITB_AHB_SLAVE_WAIT_EN
            if (WAIT_INIT == 4'd0) begin
              state_q <= ST_DATA;
            end else begin
              state_q  <= ST_WAIT;
              hready_q <= 1'b0;
              cnt_q    <= WAIT_INIT;
            end
`else
            state_q <= ST_DATA;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
`ifdef MINITB_AHB_SLAVE_WAIT_EN
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q  <= ST_DATA;
            hready_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q  <= ST_IDLE;
          hready_q <= 1'b1;
        end
      endcase
    end
  end

  minitb_ahb_ram #(
    .AW(addrWidth),
    .DW(dataWidth)
  ) u_ram (
    .clk_i   (hclk),
    .rst_n_i (hresetn),
    .we_i    (wr_commit_s && hresetn),
    .waddr_i (addr_q),
    .wdata_i (bus.hwdata),
    .re_i    (re_s && !bypass_s),
    .raddr_i (rd_addr_s),
    .rdata_o (ram_rdata_s)
  );

  assign bus.hready = hready_q;
  assign bus.hrdata = bypass_q ? fwd_q : ram_rdata_s;
endmodule
